bb_boot_copier: RTL



---
 rtl/bb_boot_copier.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bb_boot_copier.sv
// Blackbone-bus boot copier: copies WORDS words from SRC_BASE to DST_BASE
// using an RD/CAP/WR sequence per word, and holds the CPU in reset until the first copy completes.
module bb_boot_copier #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   SRC_BASE = '0,
  parameter logic [AW-1:0]   DST_BASE = AW'(32'h0001_0000),
  parameter int              WORDS    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic [AW-1:0] bb_addr_o,
  output logic [DW-1:0] bb_dout_o,
  output logic          bb_en_o,
  output logic          bb_we_o,
  input  logic [DW-1:0] bb_din_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          cpu_rst_o
);

  localparam int            RW      = (WORDS < 1) ? 1 : $clog2(WORDS + 1);
  localparam logic [RW-1:0] WORDS_R = RW'(WORDS);
  localparam logic [RW-1:0] ONE_R   = RW'(1);
  localparam logic [AW-1:0] STEP    = AW'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cpu_rst_q, cpu_rst_d;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    done_d    = done_q;
    cpu_rst_d = cpu_rst_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d   = SRC_BASE;
          dst_d   = DST_BASE;
          rem_d   = WORDS_R;
          done_d  = 1'b0;
          state_d = (WORDS == 0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        data_d  = bb_din_i;
        state_d = S_WR;
      end
      S_WR: begin
        src_d   = src_q + STEP;
        dst_d   = dst_q + STEP;
        rem_d   = rem_q - ONE_R;
        state_d = (rem_q == ONE_R) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done_d    = 1'b1;
        cpu_rst_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs are registered, so they are derived from the state being entered.
  always_comb begin
    addr_d = addr_q;
    dout_d = dout_q;
    en_d   = 1'b0;
    we_d   = 1'b0;
    busy_d = 1'b0;

    case (state_d)
      S_RD: begin
        addr_d = src_d;
        en_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_CAP: begin
        addr_d = src_d;
        busy_d = 1'b1;
      end
      S_WR: begin
        addr_d = dst_d;
        dout_d = data_d;
        en_d   = 1'b1;
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      en_q      <= en_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign bb_addr_o = addr_q;
  assign bb_dout_o = dout_q;
  assign bb_en_o   = en_q;
  assign bb_we_o   = we_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cpu_rst_o = cpu_rst_q;

endmodule
